// File: rtl/ram_2r1w_pipe_if.sv
// Request/response bundle for the two-port memory: instruction fetch port and
// data read/write port, each with valid/ready request and response handshakes.
interface ram_2r1w_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_W-1:0]     imem_raddr;
  logic                  imem_rsp_valid;
  logic                  imem_rsp_ready;
  logic [DATA_W-1:0]     imem_rdata;
  logic                  imem_err;

  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_wen;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W/8-1:0]   dmem_wmask;
  logic [DATA_W-1:0]     dmem_wdata;
  logic                  dmem_rsp_valid;
  logic                  dmem_rsp_ready;
  logic [DATA_W-1:0]     dmem_rdata;
  logic                  dmem_err;

  modport master (
    output imem_req_valid, imem_raddr, imem_rsp_ready,
    output dmem_req_valid, dmem_wen, dmem_addr, dmem_wmask, dmem_wdata, dmem_rsp_ready,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, imem_err,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata, dmem_err
  );

  modport slave (
    input  imem_req_valid, imem_raddr, imem_rsp_ready,
    input  dmem_req_valid, dmem_wen, dmem_addr, dmem_wmask, dmem_wdata, dmem_rsp_ready,
    output imem_req_ready, imem_rsp_valid, imem_rdata, imem_err,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata, dmem_err
  );
endinterface

// File: rtl/ram_2r1w_pipe.sv
// Dual-port memory model: fetch read port plus byte-masked data read/write port,
// each with a single registered response stage and valid/ready flow control.
module ram_2r1w_pipe #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000)
) (
  input  logic               clock,
  input  logic               reset_n,
  ram_2r1w_pipe_if.slave     bus
);

  localparam int unsigned       BYTES      = DATA_W / 8;
  localparam int unsigned       LSB_W      = $clog2(BYTES);
  localparam int unsigned       IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   SPAN       = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return ((a & ALIGN_MASK) == '0) && (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> LSB_W);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              i_vld_q, i_vld_d, i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_vld_q, d_vld_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              i_rdy, d_rdy, i_acc, d_acc, i_legal, d_legal, d_wr;
  logic [IDX_W-1:0]  i_idx, d_idx;
  logic [DATA_W-1:0] i_word, d_word;

  assign i_rdy   = !i_vld_q || bus.imem_rsp_ready;
  assign d_rdy   = !d_vld_q || bus.dmem_rsp_ready;
  assign i_acc   = reset_n && bus.imem_req_valid && i_rdy;
  assign d_acc   = reset_n && bus.dmem_req_valid && d_rdy;
  assign i_legal = addr_legal(bus.imem_raddr);
  assign d_legal = addr_legal(bus.dmem_addr);
  assign i_idx   = word_idx(bus.imem_raddr);
  assign d_idx   = word_idx(bus.dmem_addr);
  assign d_wr    = d_acc && bus.dmem_wen && d_legal;

  // Fetch sees a same-cycle data write to its word (write-first merge).
  always_comb begin
    i_word = mem_q[i_idx];
    if (d_wr && (d_idx == i_idx)) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (bus.dmem_wmask[b]) i_word[8*b +: 8] = bus.dmem_wdata[8*b +: 8];
      end
    end
    d_word = mem_q[d_idx];
  end

  always_comb begin
    i_vld_d   = i_vld_q;
    i_err_d   = i_err_q;
    i_rdata_d = i_rdata_q;
    if (i_acc) begin
      i_vld_d   = 1'b1;
      i_err_d   = !i_legal;
      i_rdata_d = i_legal ? i_word : '0;
    end else if (bus.imem_rsp_ready) begin
      i_vld_d   = 1'b0;
    end

    d_vld_d   = d_vld_q;
    d_err_d   = d_err_q;
    d_rdata_d = d_rdata_q;
    if (d_acc) begin
      d_vld_d   = 1'b1;
      d_err_d   = !d_legal;
      d_rdata_d = (d_legal && !bus.dmem_wen) ? d_word : '0;
    end else if (bus.dmem_rsp_ready) begin
      d_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      i_vld_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_vld_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      i_vld_q   <= i_vld_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_vld_q   <= d_vld_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Storage is not reset; d_wr is already gated by reset_n.
  always_ff @(posedge clock) begin
    if (d_wr) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (bus.dmem_wmask[b]) mem_q[d_idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.imem_req_ready = i_rdy;
  assign bus.imem_rsp_valid = i_vld_q;
  assign bus.imem_rdata     = i_rdata_q;
  assign bus.imem_err       = i_err_q;
  assign bus.dmem_req_ready = d_rdy;
  assign bus.dmem_rsp_valid = d_vld_q;
  assign bus.dmem_rdata     = d_rdata_q;
  assign bus.dmem_err       = d_err_q;

endmodule

// File: tb/tb_ram_2r1w_pipe.sv
// Self-checking bench for ram_2r1w_pipe: directed vectors, corner sequences and
// random traffic against a word/byte-level reference model.
module tb_ram_2r1w_pipe;

  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SPAN = 1024 * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_2r1w_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  ram_2r1w_pipe #(
    .DATA_W   (32),
    .DEPTH    (1024),
    .ADDR_W   (32),
    .BASE_ADDR(32'h8000_0000)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sparse word store with per-byte "written" flags.
  logic [31:0] ref_mem [int];
  logic [3:0]  ref_kn  [int];

  typedef struct {
    bit          v;
    bit          err;
    logic [31:0] data;
    bit          known;
  } rsp_t;

  rsp_t ip = '{v: 1'b0, err: 1'b0, data: '0, known: 1'b1};
  rsp_t dp = '{v: 1'b0, err: 1'b0, data: '0, known: 1'b1};

  function automatic bit is_legal(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (a[1:0] == 2'b00) && (x >= BASE) && (x < BASE + SPAN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((64'(a) - BASE) / 4);
  endfunction

  // One clock: check readiness, predict accepts, advance, check responses.
  task automatic step();
    rsp_t        ni, nd;
    bit          ia, da, ir, dr, exp_ir, exp_dr;
    int          k;
    logic [31:0] w;
    logic [3:0]  kn;
    @(negedge clk);
    exp_ir = !ip.v || bus.imem_rsp_ready;
    exp_dr = !dp.v || bus.dmem_rsp_ready;
    chk("imem_req_ready", bus.imem_req_ready, exp_ir);
    chk("dmem_req_ready", bus.dmem_req_ready, exp_dr);
    ia = rst_n && bus.imem_req_valid && exp_ir;
    da = rst_n && bus.dmem_req_valid && exp_dr;
    ir = bus.imem_rsp_ready;
    dr = bus.dmem_rsp_ready;

    ni = '{v: 1'b1, err: !is_legal(bus.imem_raddr), data: '0, known: 1'b1};
    if (is_legal(bus.imem_raddr)) begin
      k  = widx(bus.imem_raddr);
      w  = ref_mem.exists(k) ? ref_mem[k] : '0;
      kn = ref_kn.exists(k) ? ref_kn[k] : '0;
      if (da && bus.dmem_wen && is_legal(bus.dmem_addr) && widx(bus.dmem_addr) == k) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.dmem_wmask[b]) begin
            w[8*b +: 8] = bus.dmem_wdata[8*b +: 8];
            kn[b] = 1'b1;
          end
        end
      end
      ni.data  = w;
      ni.known = (kn == 4'hF);
    end

    nd = '{v: 1'b1, err: !is_legal(bus.dmem_addr), data: '0, known: 1'b1};
    if (is_legal(bus.dmem_addr)) begin
      k  = widx(bus.dmem_addr);
      w  = ref_mem.exists(k) ? ref_mem[k] : '0;
      kn = ref_kn.exists(k) ? ref_kn[k] : '0;
      if (!bus.dmem_wen) begin
        nd.data  = w;
        nd.known = (kn == 4'hF);
      end else if (da) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.dmem_wmask[b]) begin
            w[8*b +: 8] = bus.dmem_wdata[8*b +: 8];
            kn[b] = 1'b1;
          end
        end
        ref_mem[k] = w;
        ref_kn[k]  = kn;
      end
    end

    @(posedge clk);
    #1;
    if (!rst_n) begin
      ip.v = 1'b0;
      dp.v = 1'b0;
    end else begin
      if (ia) ip = ni;
      else if (ir) ip.v = 1'b0;
      if (da) dp = nd;
      else if (dr) dp.v = 1'b0;
    end
    chk("imem_rsp_valid", bus.imem_rsp_valid, ip.v);
    chk("dmem_rsp_valid", bus.dmem_rsp_valid, dp.v);
    if (ip.v) begin
      chk("imem_err", bus.imem_err, ip.err);
      if (ip.known) chk("imem_rdata", bus.imem_rdata, ip.data);
    end
    if (dp.v) begin
      chk("dmem_err", bus.dmem_err, dp.err);
      if (dp.known) chk("dmem_rdata", bus.dmem_rdata, dp.data);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 16) return 32'(BASE + 4 * $urandom_range(0, 7));
    if (r == 16) return 32'(BASE + 4 * $urandom_range(0, 7) + $urandom_range(1, 3));
    if (r == 17) return 32'(BASE - 4);
    if (r == 18) return 32'(BASE + SPAN);
    return 32'(BASE + SPAN - 4);
  endfunction

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  initial begin
    tbl[0]  = '{1'b1, 32'h8000_0000, 4'hF, 32'h0000_0013, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h8000_0004, 4'hF, 32'h0010_0093, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 32'h8000_0010, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h8000_0010, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'h11BB_33DD};
    tbl[5]  = '{1'b1, 32'h8000_0020, 4'hF, 32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h8000_0002, 4'h0, 32'h0,         1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h7FFF_FFFC, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h8000_1000, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h8000_1000, 4'h0, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,         1'b1, 32'h0};
    tbl[11] = '{1'b1, 32'h8000_0002, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 32'h8000_0000, 4'h0, 32'h0,         1'b0, 32'h0000_0013};
    tbl[13] = '{1'b1, 32'h8000_0FFC, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h8000_0FFC, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};

    bus.imem_req_valid = 1'b0;
    bus.imem_raddr     = '0;
    bus.imem_rsp_ready = 1'b1;
    bus.dmem_req_valid = 1'b0;
    bus.dmem_wen       = 1'b0;
    bus.dmem_addr      = '0;
    bus.dmem_wmask     = '0;
    bus.dmem_wdata     = '0;
    bus.dmem_rsp_ready = 1'b1;

    rst_n = 1'b0;
    step();
    step();
    chk("reset_imem_rdata", bus.imem_rdata, 32'h0);
    chk("reset_imem_err", bus.imem_err, 1'b0);
    chk("reset_dmem_rdata", bus.dmem_rdata, 32'h0);
    chk("reset_dmem_err", bus.dmem_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Back-to-back data vectors, consumer always ready
    for (int i = 0; i < NVEC; i++) begin
      bus.dmem_req_valid = 1'b1;
      bus.dmem_wen       = tbl[i].wen;
      bus.dmem_addr      = tbl[i].addr;
      bus.dmem_wmask     = tbl[i].mask;
      bus.dmem_wdata     = tbl[i].wdata;
      step();
      chk($sformatf("vec%0d_valid", i), bus.dmem_rsp_valid, 1'b1);
      chk($sformatf("vec%0d_err", i), bus.dmem_err, tbl[i].eerr);
      chk($sformatf("vec%0d_rdata", i), bus.dmem_rdata, tbl[i].erd);
    end
    bus.dmem_req_valid = 1'b0;
    step();

    // Back-to-back fetches
    bus.imem_req_valid = 1'b1;
    bus.imem_raddr     = 32'h8000_0000;
    step();
    chk("fetch0_rdata", bus.imem_rdata, 32'h0000_0013);
    chk("fetch0_err", bus.imem_err, 1'b0);
    bus.imem_raddr = 32'h8000_0004;
    step();
    chk("fetch1_valid", bus.imem_rsp_valid, 1'b1);
    chk("fetch1_rdata", bus.imem_rdata, 32'h0010_0093);

    // Fetch and data write to the same word in one cycle
    bus.imem_raddr     = 32'h8000_0020;
    bus.dmem_req_valid = 1'b1;
    bus.dmem_wen       = 1'b1;
    bus.dmem_addr      = 32'h8000_0020;
    bus.dmem_wmask     = 4'b1100;
    bus.dmem_wdata     = 32'hFFFF_FFFF;
    step();
    chk("wfirst_imem_rdata", bus.imem_rdata, 32'hFFFF_0000);
    chk("wfirst_dmem_ack_err", bus.dmem_err, 1'b0);
    chk("wfirst_dmem_ack_rdata", bus.dmem_rdata, 32'h0);
    bus.imem_req_valid = 1'b0;

    // Stall: response held 3 cycles, next request waits then goes with no bubble
    bus.dmem_wen  = 1'b0;
    bus.dmem_addr = 32'h8000_0010;
    step();
    bus.dmem_rsp_ready = 1'b0;
    bus.dmem_addr      = 32'h8000_0004;
    #1;
    chk("stall_req_ready", bus.dmem_req_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_rdata", bus.dmem_rdata, 32'h11BB_33DD);
      chk("stall_hold_valid", bus.dmem_rsp_valid, 1'b1);
      chk("stall_req_ready", bus.dmem_req_ready, 1'b0);
    end
    bus.dmem_rsp_ready = 1'b1;
    step();
    chk("stall_next_rdata", bus.dmem_rdata, 32'h0010_0093);
    bus.dmem_req_valid = 1'b0;
    step();

    // Reset while both ports hold a response
    bus.imem_req_valid = 1'b1;
    bus.imem_raddr     = 32'h8000_0000;
    bus.dmem_req_valid = 1'b1;
    bus.dmem_addr      = 32'h8000_0004;
    step();
    bus.imem_req_valid = 1'b0;
    bus.dmem_req_valid = 1'b0;
    bus.imem_rsp_ready = 1'b0;
    bus.dmem_rsp_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_imem_valid", bus.imem_rsp_valid, 1'b0);
    chk("rst_dmem_valid", bus.dmem_rsp_valid, 1'b0);
    rst_n = 1'b1;
    bus.imem_rsp_ready = 1'b1;
    bus.dmem_rsp_ready = 1'b1;
    bus.imem_req_valid = 1'b1;
    bus.imem_raddr     = 32'h8000_0020;
    bus.dmem_req_valid = 1'b1;
    bus.dmem_addr      = 32'h8000_0010;
    step();
    chk("post_rst_dmem_rdata", bus.dmem_rdata, 32'h11BB_33DD);
    chk("post_rst_imem_rdata", bus.imem_rdata, 32'hFFFF_0000);

    // Random traffic on both ports against the model
    for (int i = 0; i < 500; i++) begin
      rst_n              = ($urandom_range(0, 63) != 0);
      bus.imem_req_valid = $urandom_range(0, 1) == 1;
      bus.imem_raddr     = pick_addr();
      bus.imem_rsp_ready = $urandom_range(0, 9) < 7;
      bus.dmem_req_valid = $urandom_range(0, 1) == 1;
      bus.dmem_wen       = $urandom_range(0, 1) == 1;
      bus.dmem_addr      = pick_addr();
      bus.dmem_wmask     = 4'($urandom);
      bus.dmem_wdata     = $urandom;
      bus.dmem_rsp_ready = $urandom_range(0, 9) < 7;
      step();
    end
    rst_n = 1'b1;
    bus.imem_req_valid = 1'b0;
    bus.dmem_req_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
